// File: rtl/aes_pkg.sv
// Shared AES types for the decryption datapath: state/word typedefs, the
// inverse sub/shift FSM encoding and a column extraction helper.
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_word_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} inv_ss_state_e;

    // Column c of a column-major state; byte r of the column sits at [31-8r -: 8].
    function automatic aes_word_t col_word(aes_state_t state, logic [1:0] c);
        return state[127 - 32*int'(c) -: 32];
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box applied to each of the four bytes of a word.
module aes_inv_sbox (
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    // Entry x lives at InvSbox[2047-8x -: 8].
    localparam logic [2047:0] InvSbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    always_comb begin
        data_o = '0;
        for (int i = 0; i < 4; i++) begin
            data_o[8*i +: 8] = InvSbox[2047 - 8*int'(data_i[8*i +: 8]) -: 8];
        end
    end

endmodule

// File: rtl/aes_inv_sub_shift.sv
// Decryption round stage: InvShiftRows, InvSubBytes, then AddRoundKey.
// Iterates one column per cycle; AES_INV_SUB_SHIFT_PARALLEL_EN does all columns at once.
module aes_inv_sub_shift
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    inv_ss_state_e state_q, state_d;
    aes_state_t    st_q, st_d, key_q, key_d, res_q, res_d;
    logic [1:0]    col_q, col_d;
    logic          accept;

    // Output column c takes row r from source column (c - r) mod 4.
    function automatic aes_word_t inv_shift_word(aes_state_t s, logic [1:0] c);
        aes_word_t w, src;
        w = '0;
        for (int r = 0; r < 4; r++) begin
            src = col_word(s, c - 2'(r));
            w[31 - 8*r -: 8] = src[31 - 8*r -: 8];
        end
        return w;
    endfunction

`ifdef AES_INV_SUB_SHIFT_PARALLEL_EN
    aes_word_t sh_w [4];
    aes_word_t sb_w [4];

    for (genvar c = 0; c < 4; c++) begin : g_sbox
        assign sh_w[c] = inv_shift_word(st_q, 2'(c));
        aes_inv_sbox u_inv_sbox (
            .data_i (sh_w[c]),
            .data_o (sb_w[c])
        );
    end
`else
    aes_word_t sh_w, sb_w;

    assign sh_w = inv_shift_word(st_q, col_q);

    aes_inv_sbox u_inv_sbox (
        .data_i (sh_w),
        .data_o (sb_w)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            st_q    <= '0;
            key_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            st_q    <= st_d;
            key_q   <= key_d;
            res_q   <= res_d;
        end
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        st_d    = st_q;
        key_d   = key_q;
        res_d   = res_q;
        if (accept) begin
            st_d  = in_state;
            key_d = in_key;
            col_d = '0;
        end
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = BUSY;
            end
            BUSY: begin
`ifdef AES_INV_SUB_SHIFT_PARALLEL_EN
                res_d   = {sb_w[0], sb_w[1], sb_w[2], sb_w[3]} ^ key_q;
                state_d = DONE;
`else
                res_d[127 - 32*int'(col_q) -: 32] = sb_w ^ col_word(key_q, col_q);
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) state_d = DONE;
`endif
            end
            DONE: begin
                if (out_ready) state_d = accept ? BUSY : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        out_state = res_q;
    end

endmodule
